// File: rtl/imem_responder_if.sv
// ----------------------------------------------------------------------------
// imem_responder_if
// Fetch-port bundle between the fetch stage (master) and the instruction
// memory responder (slave).
//   req_valid/req_ready/req_addr : fetch request handshake and byte address
//   flush                        : redirect, discards in-flight/held response
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata/rsp_addr/rsp_fault : instruction word, its address, fault flag
// ----------------------------------------------------------------------------
interface imem_responder_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic [XLEN-1:0] rsp_addr;
    logic            rsp_fault;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_fault
    );
endinterface

// File: rtl/imem_responder.sv
// ----------------------------------------------------------------------------
// imem_responder
// Word-organised instruction memory serving the fetch port, with programmable
// wait states, misaligned/out-of-range fault reporting and a loader write port.
// Ports:
//   clk            : clock, all logic on posedge
//   reset          : asynchronous active-low reset
//   bus            : imem_responder_if.slave fetch request/response bundle
//   ld_we/ld_addr/ld_wdata : loader write (word aligned, out of range dropped)
//   stat_req_cnt   : accepted requests (wraps)
//   stat_fault_cnt : faulted responses (saturates)
// Optional feature: define IMEM_STATS_EN to build the statistics counters;
// otherwise the stat ports are tied to zero.
// ----------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter int unsigned     WAIT_STATES = 0,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_responder_if.slave       bus,
    input  logic                  ld_we,
    input  logic [XLEN-1:0]       ld_addr,
    input  logic [XLEN-1:0]       ld_wdata,
    output logic [31:0]           stat_req_cnt,
    output logic [15:0]           stat_fault_cnt
);
    localparam int unsigned     AW      = $clog2(DEPTH_WORDS);
    localparam logic [XLEN:0]   SPAN    = (XLEN+1)'(64'(DEPTH_WORDS) * 64'd4);
    localparam logic [3:0]      WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_addr_q;
    logic            rsp_fault_q;
    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic            req_ready, accept, load_rsp;
    logic [XLEN-1:0] fet_addr, fet_off, ld_off, rd_word;
    logic            fet_fault, ld_ok, ld_hit;

    // The memory is sampled on the edge that enters RESP. From WAIT the
    // address comes from the latch; with zero wait states it is the request
    // being accepted this very cycle.
    assign fet_addr  = (state_q == S_WAIT) ? addr_q : bus.req_addr;
    assign fet_off   = fet_addr - BASE_ADDR;
    assign fet_fault = (fet_addr[1:0] != 2'b00) || (fet_addr < BASE_ADDR) ||
                       ({1'b0, fet_off} >= SPAN);

    assign ld_off = ld_addr - BASE_ADDR;
    assign ld_ok  = (ld_addr >= BASE_ADDR) && ({1'b0, ld_off} < SPAN);
    // Loader write landing on the same word as the read is forwarded.
    assign ld_hit = ld_we && ld_ok && (ld_off[AW+1:2] == fet_off[AW+1:2]);

    always_comb begin
        if (fet_fault)   rd_word = NOP;
        else if (ld_hit) rd_word = ld_wdata;
        else             rd_word = mem_q[fet_off[AW+1:2]];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        load_rsp  = 1'b0;
        req_ready = !bus.flush &&
                    ((state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready));
        accept    = bus.req_valid && req_ready;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d  = S_RESP;
                        load_rsp = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready && !accept) state_d = S_IDLE;
                end
                default: ;
            endcase
            if (accept) begin
                addr_d = bus.req_addr;
                if (WAIT_STATES == 0) begin
                    state_d  = S_RESP;
                    load_rsp = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WS_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (load_rsp) begin
                rsp_rdata_q <= rd_word;
                rsp_addr_q  <= fet_addr;
                rsp_fault_q <= fet_fault;
            end
        end
    end

    // Program store is never reset so an image survives a core reset.
    always_ff @(posedge clk) begin
        if (ld_we && ld_ok) mem_q[ld_off[AW+1:2]] <= ld_wdata;
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_fault = rsp_fault_q;

`ifdef IMEM_STATS_EN
    logic [31:0] req_cnt_q;
    logic [15:0] fault_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_cnt_q   <= '0;
            fault_cnt_q <= '0;
        end else begin
            if (accept) req_cnt_q <= req_cnt_q + 32'd1;
            if (load_rsp && fet_fault && (fault_cnt_q != '1))
                fault_cnt_q <= fault_cnt_q + 16'd1;
        end
    end

    assign stat_req_cnt   = req_cnt_q;
    assign stat_fault_cnt = fault_cnt_q;
`else
    assign stat_req_cnt   = '0;
    assign stat_fault_cnt = '0;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// ----------------------------------------------------------------------------
// tb_imem_responder
// Three responders (0, 3 and 2 wait states) share one stimulus set; `sel`
// picks whose outputs are observed. Accepted requests are queued and checked
// against a small memory/fault model when the response handshake completes.
// ----------------------------------------------------------------------------
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, flush, rsp_ready, ld_we;
    logic [31:0] req_addr, ld_addr, ld_wdata;
    logic [1:0]  sel;

    always #5 clk = ~clk;

`ifdef IMEM_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    imem_responder_if #(.XLEN(32)) b0 ();
    imem_responder_if #(.XLEN(32)) b3 ();
    imem_responder_if #(.XLEN(32)) b2 ();

    assign b0.req_valid = req_valid; assign b0.req_addr = req_addr;
    assign b0.flush     = flush;     assign b0.rsp_ready = rsp_ready;
    assign b3.req_valid = req_valid; assign b3.req_addr = req_addr;
    assign b3.flush     = flush;     assign b3.rsp_ready = rsp_ready;
    assign b2.req_valid = req_valid; assign b2.req_addr = req_addr;
    assign b2.flush     = flush;     assign b2.rsp_ready = rsp_ready;

    logic [31:0] s0_req, s3_req, s2_req;
    logic [15:0] s0_flt, s3_flt, s2_flt;

    imem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .stat_req_cnt(s0_req), .stat_fault_cnt(s0_flt));
    imem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
        .clk(clk), .reset(reset), .bus(b3), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .stat_req_cnt(s3_req), .stat_fault_cnt(s3_flt));
    imem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
        .clk(clk), .reset(reset), .bus(b2), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .stat_req_cnt(s2_req), .stat_fault_cnt(s2_flt));

    logic        o_req_ready, o_rsp_valid, o_rsp_fault;
    logic [31:0] o_rsp_rdata, o_rsp_addr;

    always_comb begin
        o_req_ready = b0.req_ready;
        o_rsp_valid = b0.rsp_valid;
        o_rsp_fault = b0.rsp_fault;
        o_rsp_rdata = b0.rsp_rdata;
        o_rsp_addr  = b0.rsp_addr;
        case (sel)
            2'd1: begin
                o_req_ready = b3.req_ready; o_rsp_valid = b3.rsp_valid;
                o_rsp_fault = b3.rsp_fault; o_rsp_rdata = b3.rsp_rdata;
                o_rsp_addr  = b3.rsp_addr;
            end
            2'd2: begin
                o_req_ready = b2.req_ready; o_rsp_valid = b2.rsp_valid;
                o_rsp_fault = b2.rsp_fault; o_rsp_rdata = b2.rsp_rdata;
                o_rsp_addr  = b2.rsp_addr;
            end
            default: ;
        endcase
    end

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] sb_q [$];
    logic [31:0] mm [int unsigned];

    function automatic logic exp_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score the response handshake and queue any accept,
    // then advance to the next falling edge.
    task automatic tick();
        logic [31:0] a;
        #1;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (o_rsp_valid && rsp_ready) begin
                chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    a = sb_q.pop_front();
                    chk("sb_rsp_addr", o_rsp_addr, a);
                    chk("sb_rsp_fault", 32'(o_rsp_fault), 32'(exp_fault(a)));
                    chk("sb_rsp_rdata", o_rsp_rdata, exp_fault(a) ? 32'h0000_0013 : mm[a >> 2]);
                end
            end
            if (req_valid && o_req_ready) sb_q.push_back(req_addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
        if (a < 32'h0000_1000) mm[a >> 2] = d;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1; req_valid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        ld_we = 1'b0; req_addr = '0; ld_addr = '0; ld_wdata = '0; sel = 2'd0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_fault", 32'(o_rsp_fault), 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_addr", o_rsp_addr, 32'd0);
        chk("rst_stat_req", s0_req, 32'd0);
        chk("rst_stat_fault", 32'(s0_flt), 32'd0);
        reset = 1'b1;
        #1 chk("idle_req_ready", 32'(o_req_ready), 32'd1);

        // Program image; the out-of-range write would alias word 0 if not dropped
        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h0010_0113);
        load(32'h8, 32'h1234_5678);
        load(32'h10, 32'h1111_1111);
        load(32'h1000, 32'hCAFE_F00D);

        // Zero wait states, back-to-back fetches
        sel = 2'd0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        tick();
        chk("b2b_valid_c1", 32'(o_rsp_valid), 32'd1);
        req_addr = 32'h4;
        tick();
        chk("b2b_valid_c2", 32'(o_rsp_valid), 32'd1);
        chk("b2b_rdata_c2", o_rsp_rdata, 32'h0010_0113);
        req_valid = 1'b0;
        tick();
        chk("b2b_idle", 32'(o_rsp_valid), 32'd0);

        // Faults: misaligned and past the end of memory
        req_valid = 1'b1; req_addr = 32'h6;
        tick();
        chk("flt_mis_fault", 32'(o_rsp_fault), 32'd1);
        chk("flt_mis_rdata", o_rsp_rdata, 32'h0000_0013);
        req_addr = 32'h1000;
        tick();
        chk("flt_oor_fault", 32'(o_rsp_fault), 32'd1);
        req_valid = 1'b0;
        tick();
        chk("stat_fault_cnt", 32'(s0_flt), STATS_ON ? 32'd2 : 32'd0);
        chk("stat_req_cnt", s0_req, STATS_ON ? 32'd4 : 32'd0);

        // Three wait states
        do_flush();
        sel = 2'd1; req_valid = 1'b1; req_addr = 32'h8;
        #1 chk("ws3_ready_idle", 32'(o_req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("ws3_wait_valid", 32'(o_rsp_valid), 32'd0);
            chk("ws3_wait_ready", 32'(o_req_ready), 32'd0);
            tick();
        end
        chk("ws3_valid_c4", 32'(o_rsp_valid), 32'd1);
        tick();
        chk("ws3_idle", 32'(o_rsp_valid), 32'd0);

        // Held response stays stable, then flush beats a new request
        do_flush();
        sel = 2'd0; rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(o_rsp_valid), 32'd1);
            chk("hold_rdata", o_rsp_rdata, 32'h0010_0113);
            chk("hold_addr", o_rsp_addr, 32'h4);
            chk("hold_fault", 32'(o_rsp_fault), 32'd0);
            tick();
        end
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
        #1 chk("flush_no_ready", 32'(o_req_ready), 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        chk("flush_valid", 32'(o_rsp_valid), 32'd0);
        chk("flush_idle_ready", 32'(o_req_ready), 32'd1);

        // Two wait states, loader write forwarded on the RESP-entry edge
        do_flush();
        sel = 2'd2; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        tick();
        ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
        mm[32'h10 >> 2] = 32'hDEAD_BEEF;
        tick();
        ld_we = 1'b0;
        chk("wf_valid", 32'(o_rsp_valid), 32'd1);
        chk("wf_rdata", o_rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // Reset in the middle of a wait-state transaction
        do_flush();
        sel = 2'd1; req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        sb_q.delete();
        #1 chk("rst_mid_valid", 32'(o_rsp_valid), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_valid", 32'(o_rsp_valid), 32'd0);
            tick();
        end
        chk("post_rst_stat", s0_req, 32'd0);
        sel = 2'd0; req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("post_rst_mem0", o_rsp_rdata, 32'h0050_0093);
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
